// File: rtl/pcm_filter_ctrl.sv
// Sequencing controller for the PCM moving-average filter: flushes the filter
// history with zeros, discards warm-up outputs, then emits decimated, tagged samples.
module pcm_filter_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIR_TAPS    = 64,
    parameter int DECIM_WIDTH = 8,
    parameter int SEQ_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic                   clear_status,
    input  logic                   up_valid,
    input  logic [DATA_WIDTH-1:0]  up_sample,
    output logic                   filt_in_valid,
    output logic [DATA_WIDTH-1:0]  filt_in_sample,
    input  logic                   filt_out_valid,
    input  logic [DATA_WIDTH-1:0]  filt_out_sample,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_sample,
    output logic [SEQ_WIDTH-1:0]   out_seq,
    output logic [1:0]             state,
    output logic                   overrun
);

    localparam int FLUSH_W = $clog2(FIR_TAPS);
    localparam int DISC_W  = $clog2(2 * FIR_TAPS + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FIR_TAPS - 1);
    localparam logic [DISC_W-1:0]  DISC_LAST  = DISC_W'(2 * FIR_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [DISC_W-1:0]      disc_cnt_q, disc_cnt_d;
    logic [DECIM_WIDTH-1:0] dec_r_q, dec_r_d;
    logic [DECIM_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic [SEQ_WIDTH-1:0]   seq_cnt_q, seq_cnt_d;
    logic                   filt_in_valid_q, filt_in_valid_d;
    logic [DATA_WIDTH-1:0]  filt_in_sample_q, filt_in_sample_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_sample_q, out_sample_d;
    logic [SEQ_WIDTH-1:0]   out_seq_q, out_seq_d;
    logic                   overrun_q, overrun_d;

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        disc_cnt_d       = disc_cnt_q;
        dec_r_d          = dec_r_q;
        dec_cnt_d        = dec_cnt_q;
        seq_cnt_d        = seq_cnt_q;
        filt_in_valid_d  = 1'b0;
        filt_in_sample_d = '0;
        out_valid_d      = 1'b0;
        out_sample_d     = out_sample_q;
        out_seq_d        = out_seq_q;

        // A drop during FLUSH outranks a simultaneous clear.
        if (state_q == ST_FLUSH && up_valid) begin
            overrun_d = 1'b1;
        end else if (clear_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d         = ST_FLUSH;
                    dec_r_d         = (decim == '0) ? DECIM_WIDTH'(1) : decim;
                    flush_cnt_d     = '0;
                    disc_cnt_d      = '0;
                    dec_cnt_d       = '0;
                    seq_cnt_d       = '0;
                    out_seq_d       = '0;
                    filt_in_valid_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The IDLE->FLUSH edge already issued zero write 0, so the
                // last FLUSH cycle issues nothing.
                filt_in_valid_d = (flush_cnt_q != FLUSH_LAST);
                flush_cnt_d     = flush_cnt_q + FLUSH_W'(1);
                if (filt_out_valid) disc_cnt_d = disc_cnt_q + DISC_W'(1);
                if (flush_cnt_q == FLUSH_LAST) state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                filt_in_valid_d  = up_valid;
                filt_in_sample_d = up_valid ? up_sample : '0;
                if (filt_out_valid) begin
                    if (disc_cnt_q == DISC_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        disc_cnt_d = disc_cnt_q + DISC_W'(1);
                    end
                end
            end
            ST_RUN: begin
                filt_in_valid_d  = up_valid;
                filt_in_sample_d = up_valid ? up_sample : '0;
                if (filt_out_valid) begin
                    if (dec_cnt_q == '0) begin
                        out_valid_d  = 1'b1;
                        out_sample_d = filt_out_sample;
                        out_seq_d    = seq_cnt_q;
                        seq_cnt_d    = seq_cnt_q + SEQ_WIDTH'(1);
                    end
                    dec_cnt_d = (dec_cnt_q == dec_r_q - DECIM_WIDTH'(1)) ? '0
                                : dec_cnt_q + DECIM_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !enable) begin
            state_d          = ST_IDLE;
            filt_in_valid_d  = 1'b0;
            filt_in_sample_d = '0;
            out_valid_d      = 1'b0;
            out_sample_d     = out_sample_q;
            out_seq_d        = out_seq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= '0;
            disc_cnt_q       <= '0;
            dec_r_q          <= '0;
            dec_cnt_q        <= '0;
            seq_cnt_q        <= '0;
            filt_in_valid_q  <= 1'b0;
            filt_in_sample_q <= '0;
            out_valid_q      <= 1'b0;
            out_sample_q     <= '0;
            out_seq_q        <= '0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            disc_cnt_q       <= disc_cnt_d;
            dec_r_q          <= dec_r_d;
            dec_cnt_q        <= dec_cnt_d;
            seq_cnt_q        <= seq_cnt_d;
            filt_in_valid_q  <= filt_in_valid_d;
            filt_in_sample_q <= filt_in_sample_d;
            out_valid_q      <= out_valid_d;
            out_sample_q     <= out_sample_d;
            out_seq_q        <= out_seq_d;
            overrun_q        <= overrun_d;
        end
    end

    assign filt_in_valid  = filt_in_valid_q;
    assign filt_in_sample = filt_in_sample_q;
    assign out_valid      = out_valid_q;
    assign out_sample     = out_sample_q;
    assign out_seq        = out_seq_q;
    assign state          = state_q;
    assign overrun        = overrun_q;

endmodule

// File: doc/pcm_filter_ctrl.md
# pcm_filter_ctrl

Sequencing controller for the PCM moving-average filter. Sits between the upstream PCM decimator and the averaging filter, and between the filter output and the PCM sink. On enable it:
- flushes the filter history with zeros,
- discards filter outputs until the averaging window holds only real samples,
- then forwards samples with a programmable output decimation and a sequence tag.

It owns the filter's input port exclusively; the filter's reset is not used for restarts.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width (signed).
- FIR_TAPS, 64, filter window length; power of two, ≥2.
- DECIM_WIDTH, 8, width of the decimation factor.
- SEQ_WIDTH, 16, width of the output sequence counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; 1 = run, 0 = stop.
- decim  in  DECIM_WIDTH  output decimation factor; 0 is treated as 1.
- clear_status  in  1  single-cycle pulse; clears overrun.
- up_valid  in  1  upstream sample strobe.
- up_sample  in  DATA_WIDTH  upstream sample (signed).
- filt_in_valid  out  1  strobe to filter in_valid.
- filt_in_sample  out  DATA_WIDTH  to filter in_sample.
- filt_out_valid  in  1  from filter out_valid.
- filt_out_sample  in  DATA_WIDTH  from filter out_sample.
- out_valid  out  1  emitted-sample strobe.
- out_sample  out  DATA_WIDTH  emitted sample.
- out_seq  out  SEQ_WIDTH  index of the emitted sample.
- state  out  2  0=IDLE, 1=FLUSH, 2=WARMUP, 3=RUN.
- overrun  out  1  sticky; an upstream sample was dropped during FLUSH.

## Operation
- **Reset:** all outputs 0; state IDLE; all counters 0.
- **IDLE:**
  - filt_in_valid=0; up_valid and filt_out_valid are ignored; out_valid=0.
  - enable=1 → FLUSH. On this transition:
    - latch decim into dec_r (0→1);
    - clear flush_cnt, disc_cnt, dec_cnt and out_seq.
- **FLUSH:**
  - Drives filt_in_valid=1, filt_in_sample=0 on every cycle, for exactly FIR_TAPS cycles (flush_cnt 0..FIR_TAPS-1).
  - When the last flush cycle is issued → WARMUP.
  - up_valid in FLUSH is dropped and sets overrun.
- **WARMUP:**
  - Forwards upstream: filt_in_valid/filt_in_sample are up_valid/up_sample registered.
  - Counts every filt_out_valid pulse since FLUSH entry in disc_cnt; this includes outputs caused by flush writes.
  - Discards the first 2*FIR_TAPS+1 filter outputs. FIR_TAPS of these come from the zero writes, FIR_TAPS from the partially real window, and 1 because the filter sums its window before the write.
  - When the (2*FIR_TAPS+1)-th output is consumed → RUN. That output is not emitted.
- **RUN:**
  - Forwarding continues.
  - Each filt_out_valid is accepted. The first accepted output is emitted, then every dec_r-th after it: dec_cnt counts 0..dec_r-1 and emits at 0.
  - Each emission: out_sample = filt_out_sample, out_valid pulses for 1 cycle, out_seq is the tag of that sample.
  - out_seq increments after each emission and wraps modulo 2^SEQ_WIDTH. The first emitted sample has out_seq=0.
- **enable=0 in any non-IDLE state:**
  - → IDLE at the next edge; filt_in_valid=0 from that edge.
  - Any forward or emission that has not yet been registered is abandoned.
  - A later enable=1 restarts with a full FLUSH.
- **decim changes** while not in IDLE are ignored until the next restart.
- **overrun:**
  - Set by up_valid in FLUSH; cleared by clear_status.
  - Set and clear in the same cycle → set wins.
  - Unaffected by enable.
- No backpressure: the sink must accept every out_valid.

## Timing
- Upstream to filter: up_valid at edge t → filt_in_valid at t+1, in WARMUP and RUN. A strobe arriving on the cycle the FSM enters WARMUP is forwarded.
- Filter to output: filt_out_valid at edge t → out_valid/out_sample/out_seq at t+1.
- FLUSH length: filt_in_valid high for FIR_TAPS consecutive cycles, starting 1 cycle after enable rises.
- Back-to-back up_valid and filt_out_valid on every cycle are supported in all states.
- The state output reflects the registered FSM state.

## Test plan
- **Reset and idle:**
  - Stimulus: hold rst_n=0, drive up_valid toggling; then release with enable=0 for 20 cycles.
  - Required: all outputs 0; state=0; filt_in_valid never asserts.
- **Flush:**
  - Stimulus: enable rises at cycle 10 (FIR_TAPS=64).
  - Required: state=1 from cycle 11; filt_in_valid=1, sample=0 for cycles 11..74; state=2 at cycle 75.
- **Warmup discard:**
  - Stimulus: loopback filter model; constant up_sample=1000 every 4 cycles after FLUSH.
  - Required: no out_valid for the first 129 filter outputs; the first emitted sample is 1000 with out_seq=0.
- **Decimation:**
  - Stimulus: decim=3 in RUN; ramp inputs.
  - Required: out_valid on every 3rd filt_out_valid, out_seq 0,1,2,…; wrap 0xFFFF→0 checked with SEQ_WIDTH forced small (4: 15→0).
  - Stimulus: decim=0.
  - Required: behaves as decim=1.
- **Overrun:**
  - Stimulus: up_valid during FLUSH.
  - Required: overrun=1 on the next edge.
  - Stimulus: clear_status together with a new FLUSH-time up_valid.
  - Required: overrun stays 1.
  - Stimulus: clear_status alone.
  - Required: overrun=0.
- **Restart mid-run:**
  - Stimulus: drop enable in RUN for 1 cycle, then raise it.
  - Required: state 3→0→1; full 64-cycle flush; out_seq restarts at 0; no out_valid while state≠3.
